tile_scanout: RTL and testbench
===============================

Name: tile_scanout

Overview:
- Display-side scan engine that drives the tile pixel ROM (mem_tile) and consumes its asynchronous color output.
- Generates 640x480@60 raster timing and computes the tile ROM address per pixel, with the tile repeated across the screen and per-frame scroll offsets.
- Registers the ROM data and emits RGB aligned with delayed hsync/vsync/de to the video output.

Parameters:
- ADDRESS, 13, tile ROM address width; must equal TILE_W_LOG2+TILE_H_LOG2 (elaboration error otherwise).
- COLOR_BITS, 24, pixel width; matches ROM data width.
- TILE_W_LOG2, 7, log2 tile width (128 px).
- TILE_H_LOG2, 6, log2 tile height (64 px).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks (H_TOTAL=800).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (V_TOTAL=525).
- SYNC_POL, 0, sync active level (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- scroll_x  in  TILE_W_LOG2  horizontal tile offset, sampled once per frame.
- scroll_y  in  TILE_H_LOG2  vertical tile offset, sampled once per frame.
- tile_addr  out  ADDRESS  registered address to mem_tile addr.
- tile_dout  in  COLOR_BITS  mem_tile dout (combinational from tile_addr).
- rgb  out  COLOR_BITS  registered pixel color; 0 outside active area.
- hsync  out  1  horizontal sync, delayed to align with rgb.
- vsync  out  1  vertical sync, delayed to align with rgb.
- de  out  1  data enable, aligned with rgb.
- frame_start  out  1  one-clock pulse, aligned with the rgb of pixel (0,0).

Behaviour:
- Reset, async on rst=1:
  - hcnt=0, vcnt=0, latched scrolls=0, tile_addr=0, rgb=0, de=0, frame_start=0.
  - hsync and vsync are driven to the inactive level (~SYNC_POL).
- Stage 0 (counters):
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
  - Active area when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- Scroll latch:
  - On the edge where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, sx<=scroll_x and sy<=scroll_y.
  - Latched values apply for the whole following frame; mid-frame scroll changes have no visible effect.
- Stage 1 (address), every clock:
  - tile_addr <= {(vcnt[TILE_H_LOG2-1:0]+sy) mod 2^TILE_H_LOG2, (hcnt[TILE_W_LOG2-1:0]+sx) mod 2^TILE_W_LOG2}, row-major, y in the MSBs.
  - Addition wraps with carry discarded, so the tile repeats seamlessly.
  - Address is computed even in blanking; the ROM output is then masked.
  - de_d1, hs_d1, vs_d1, fs_d1 are registered alongside.
- Stage 2 (output):
  - rgb <= de_d1 ? tile_dout : 0.
  - de, hsync, vsync, frame_start <= their stage-1 values.
- Latency:
  - Counter position (h,v) at cycle n appears on rgb/de/hsync/vsync at cycle n+2.
  - All outputs share this 2-cycle delay, so relative sync timing is exactly the stage-0 timing.
- frame_start:
  - Stage 0 raises the flag when hcnt=0 and vcnt=0.
  - The flag is delayed 2 cycles, so the pulse coincides with the first active pixel.
- Reset deassertion:
  - The first rising edge moves hcnt to 1.
  - Outputs show pixel (0,0) two edges after release, with frame_start=1 and de=1.
- Reset mid-frame: all state returns to the reset values immediately (async); no partial-frame recovery.

Optional Feature:
- Macro: TILE_SCANOUT_GRID_EN.
- Defined:
  - Adds parameter GRID_COLOR (default 24'hFFFFFF, truncated to COLOR_BITS).
  - Within the active area, a pixel whose pre-scroll tile-local x or y (hcnt/vcnt low bits) equals 0 outputs GRID_COLOR instead of tile_dout.
  - The grid flag is pipelined with de, so latency is unchanged.
- Undefined: no grid logic and no GRID_COLOR parameter; rgb is always the ROM color or 0.

Test Plan:
- Release rst with scroll 0 and a ROM model where mem[a]=a:
  - 2 clocks later: de=1, frame_start=1, rgb=0.
  - Pixel (5,0) gives rgb=5.
  - Pixel (130,1) gives rgb=(1<<7)|2=130.
- Count clocks between hsync assertions = 800.
  - hsync low for 96 clocks, starting 656 clocks after de rises on the line.
  - vsync low for 2 lines per 525-line frame.
- Apply scroll_x=127, scroll_y=63 mid-frame:
  - Current frame is unchanged.
  - Next frame pixel (0,0) reads address {63,127}=8191.
  - Pixel (1,1) reads address 0.
- Blanking: at hcnt=700 with ROM data nonzero, rgb=0 and de=0.
- Assert rst for 1 clock mid-line at hcnt=300:
  - Outputs go to rgb=0, de=0, syncs inactive, without waiting for a clock edge.
  - Timing restarts from (0,0).
- With TILE_SCANOUT_GRID_EN: pixels (0,y), (128,y) and (x,64) output GRID_COLOR; pixel (1,1) outputs ROM data.

Source files
------------

// File: rtl/tile_scanout.sv
// 640x480 raster scan engine: walks the tile ROM with wrapping per-frame scroll and
// emits registered RGB with aligned syncs. Define TILE_SCANOUT_GRID_EN for a tile-edge grid overlay.
module tile_scanout #(
    parameter int ADDRESS     = 13,
    parameter int COLOR_BITS  = 24,
    parameter int TILE_W_LOG2 = 7,
    parameter int TILE_H_LOG2 = 6,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0
`ifdef TILE_SCANOUT_GRID_EN
    ,
    parameter logic [23:0] GRID_COLOR = 24'hFFFFFF
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TILE_W_LOG2-1:0] scroll_x,
    input  logic [TILE_H_LOG2-1:0] scroll_y,
    output logic [ADDRESS-1:0]     tile_addr,
    input  logic [COLOR_BITS-1:0]  tile_dout,
    output logic [COLOR_BITS-1:0]  rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (ADDRESS != TILE_W_LOG2 + TILE_H_LOG2) begin : g_addr_chk
            $error("tile_scanout: ADDRESS must equal TILE_W_LOG2 + TILE_H_LOG2");
        end
    endgenerate

    logic [HW-1:0]          hcnt;
    logic [VW-1:0]          vcnt;
    logic [TILE_W_LOG2-1:0] sx;
    logic [TILE_H_LOG2-1:0] sy;

    logic                   vld_p0, hs_p0, vs_p0, fs_p0;
    logic [TILE_W_LOG2-1:0] tx_p0;
    logic [TILE_H_LOG2-1:0] ty_p0;
    logic                   vld_p1, hs_p1, vs_p1, fs_p1;

    // Stage 0: raster counters; scroll is captured only at the last pixel of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            sx   <= '0;
            sy   <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
                vcnt <= '0;
                sx   <= scroll_x;
                sy   <= scroll_y;
            end else begin
                vcnt <= vcnt + VW'(1);
            end
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign vld_p0 = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_p0  = (hcnt >= HS_START && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_p0  = (vcnt >= VS_START && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign fs_p0  = (hcnt == '0) && (vcnt == '0);
    // Carry out is dropped on purpose so the tile wraps seamlessly
    assign tx_p0  = hcnt[TILE_W_LOG2-1:0] + sx;
    assign ty_p0  = vcnt[TILE_H_LOG2-1:0] + sy;

`ifdef TILE_SCANOUT_GRID_EN
    localparam logic [COLOR_BITS-1:0] GRID_C = COLOR_BITS'(GRID_COLOR);
    logic grid_p0, grid_p1;
    assign grid_p0 = vld_p0 && ((hcnt[TILE_W_LOG2-1:0] == '0) || (vcnt[TILE_H_LOG2-1:0] == '0));
`endif

    // Stage 1: ROM address and control registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_addr <= '0;
            vld_p1    <= 1'b0;
            hs_p1     <= ~SYNC_POL;
            vs_p1     <= ~SYNC_POL;
            fs_p1     <= 1'b0;
`ifdef TILE_SCANOUT_GRID_EN
            grid_p1   <= 1'b0;
`endif
        end else begin
            tile_addr <= {ty_p0, tx_p0};
            vld_p1    <= vld_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
            fs_p1     <= fs_p0;
`ifdef TILE_SCANOUT_GRID_EN
            grid_p1   <= grid_p0;
`endif
        end
    end

    // Stage 2: capture ROM data, blank outside the active area
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb         <= '0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
`ifdef TILE_SCANOUT_GRID_EN
            if (!vld_p1)
                rgb <= '0;
            else if (grid_p1)
                rgb <= GRID_C;
            else
                rgb <= tile_dout;
`else
            rgb         <= vld_p1 ? tile_dout : '0;
`endif
            de          <= vld_p1;
            hsync       <= hs_p1;
            vsync       <= vs_p1;
            frame_start <= fs_p1;
        end
    end

endmodule

// File: tb/tb_tile_scanout.sv
// Directed bench for tile_scanout: identity ROM (mem[a]=a), shortened 8-line frame
// with standard 800-clock lines so several frames fit in a short run.
module tb_tile_scanout;

    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int FRAME = 800 * (VA + VF + VS + VB);

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  scroll_x;
    logic [5:0]  scroll_y;
    logic [12:0] tile_addr;
    logic [23:0] tile_dout;
    logic [23:0] rgb;
    logic        hsync, vsync, de, frame_start;

    tile_scanout #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .tile_addr(tile_addr), .tile_dout(tile_dout), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign tile_dout = {11'd0, tile_addr};

    int ecnt;
    always @(posedge clk or posedge rst)
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] adj(input int h, input int v, input logic de_e, input logic [23:0] e);
        logic [23:0] r;
        r = e;
`ifdef TILE_SCANOUT_GRID_EN
        if (de_e && ((h % 128) == 0 || (v % 64) == 0)) r = 24'hFFFFFF;
`endif
        return r;
    endfunction

    task automatic goto(input int h, input int v, input int f);
        int t;
        t = f * FRAME + v * 800 + h + 2;
        while (ecnt < t) @(negedge clk);
        check("position", 32'(ecnt), 32'(t));
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return hsync;
            1:       return vsync;
            default: return ~de;
        endcase
    endfunction

    // Time of the next 1->0 transition of sig(which), or -1 on timeout
    task automatic wait_fall(input int which, output int t);
        logic prev, cur;
        t = -1;
        prev = sig(which);
        for (int n = 0; n < 20000 && t < 0; n++) begin
            @(negedge clk);
            cur = sig(which);
            if (prev && !cur) t = ecnt;
            prev = cur;
        end
        if (t < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_wait signal=%0d actual=none required=edge", which);
        end
    endtask

    task automatic low_width(input int which, output int w);
        w = 0;
        while (sig(which) == 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
    endtask

    typedef struct {
        int          h;
        int          v;
        int          f;
        bit          scr;
        logic        de;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, w, fr;

        vecs[0]  = '{0,   0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'd0};
        vecs[1]  = '{5,   0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd5};
        vecs[2]  = '{128, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd128};
        vecs[3]  = '{130, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd130};
        vecs[4]  = '{700, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'd0};
        vecs[5]  = '{10,  3, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd394};
        vecs[6]  = '{639, 3, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd511};
        vecs[7]  = '{640, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0};
        vecs[8]  = '{0,   5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0};
        vecs[9]  = '{700, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0};
        vecs[10] = '{0,   0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'd8191};
        vecs[11] = '{1,   1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd0};
        vecs[12] = '{5,   2, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'd132};
        vecs[13] = '{0,   4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0};

        rst      = 1'b1;
        scroll_x = 7'd0;
        scroll_y = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_rgb",   32'(rgb), 32'd0);
        check("rst_de",    32'(de), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_fs",    32'(frame_start), 32'd0);
        check("rst_addr",  32'(tile_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].scr) begin
                scroll_x = 7'd127;
                scroll_y = 6'd63;
            end
            goto(vecs[i].h, vecs[i].v, vecs[i].f);
            check($sformatf("vec%0d_rgb", i), 32'(rgb),
                  32'(adj(vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].rgb)));
            check($sformatf("vec%0d_de", i),    32'(de), 32'(vecs[i].de));
            check($sformatf("vec%0d_fs", i),    32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
            check($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
        end

        wait_fall(2, t0);
        wait_fall(0, t1);
        check("de_to_hsync", 32'(t1 - t0), 32'd656);
        low_width(0, w);
        check("hsync_width", 32'(w), 32'd96);
        wait_fall(0, t2);
        check("hsync_period", 32'(t2 - t1), 32'd800);

        wait_fall(1, t1);
        low_width(1, w);
        check("vsync_width", 32'(w), 32'd1600);
        wait_fall(1, t2);
        check("vsync_period", 32'(t2 - t1), 32'(FRAME));

        fr = (ecnt - 2) / FRAME + 1;
        goto(300, 1, fr);
        check("pre_rst_de",  32'(de), 32'd1);
        check("pre_rst_rgb", 32'(rgb), 32'(adj(300, 1, 1'b1, 24'd43)));
        #1 rst = 1'b1;
        #1;
        check("async_rgb",   32'(rgb), 32'd0);
        check("async_de",    32'(de), 32'd0);
        check("async_hsync", 32'(hsync), 32'd1);
        check("async_vsync", 32'(vsync), 32'd1);
        check("async_fs",    32'(frame_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        goto(0, 0, 0);
        check("rec_de",  32'(de), 32'd1);
        check("rec_fs",  32'(frame_start), 32'd1);
        check("rec_rgb", 32'(rgb), 32'(adj(0, 0, 1'b1, 24'd0)));
        goto(3, 0, 0);
        check("rec_rgb3", 32'(rgb), 32'(adj(3, 0, 1'b1, 24'd3)));
        check("rec_fs3",  32'(frame_start), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
